vc_partitioned_queue: RTL and testbench

VC_PARTITIONED_QUEUE -- requirements
Module: vc_partitioned_queue

---
 rtl/vc_queue_pkg.sv | 19 +
 rtl/vc_partition_queue_ctrl.sv | 84 ++++++++
 rtl/vc_partitioned_queue.sv | 124 ++++++++++++
 tb/tb_vc_partitioned_queue.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_queue_pkg.sv
// Shared queue-mode constants and a small sizing helper.
//
// VC_QUEUE_NORMAL : plain registered queue
// VC_QUEUE_PIPE   : a full partition accepts when the same partition is dequeued this cycle
// VC_QUEUE_BYPASS : an empty partition forwards the offered message straight to the consumer
// PIPE and BYPASS are independent bits and may be OR-ed together.
package vc_queue_pkg;

    localparam logic [3:0] VC_QUEUE_NORMAL = 4'b0000;
    localparam logic [3:0] VC_QUEUE_PIPE   = 4'b0001;
    localparam logic [3:0] VC_QUEUE_BYPASS = 4'b0010;

    // Width of an index into n items; never narrower than one bit so a
    // single-item selector still has a real port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_partition_queue_ctrl.sv
// Bookkeeping for one partition of the shared queue storage.
//
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   flush          : empty this partition at the next edge (wins over enq/deq)
//   enq, deq       : an entry is written / consumed at the next edge
//   enq_ptr        : slot the next enqueue writes
//   deq_ptr        : slot currently at the head
//   full, empty    : partition status
//   num_free       : free entries, 0..p_num_entries
module vc_partition_queue_ctrl #(
    parameter int  p_num_entries = 4,
    localparam int ptr_w         = $clog2(p_num_entries),
    localparam int cnt_w         = ptr_w + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq,
    input  logic             deq,
    output logic [ptr_w-1:0] enq_ptr,
    output logic [ptr_w-1:0] deq_ptr,
    output logic             full,
    output logic             empty,
    output logic [cnt_w-1:0] num_free
);

    logic [ptr_w-1:0] enq_ptr_q, enq_ptr_d;
    logic [ptr_w-1:0] deq_ptr_q, deq_ptr_d;
    logic             full_q, full_d;
    logic [cnt_w-1:0] occupancy;

    // Pointers wrap explicitly because the partition size need not be a
    // power of two.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] ptr);
        return (ptr == ptr_w'(p_num_entries - 1)) ? '0 : ptr + ptr_w'(1);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        full_d    = full_q;
        if (flush) begin
            enq_ptr_d = '0;
            deq_ptr_d = '0;
            full_d    = 1'b0;
        end else begin
            if (enq) enq_ptr_d = next_ptr(enq_ptr_q);
            if (deq) deq_ptr_d = next_ptr(deq_ptr_q);
            // Simultaneous enq+deq keeps occupancy, hence the full bit.
            if (enq && !deq)      full_d = (next_ptr(enq_ptr_q) == deq_ptr_q);
            else if (deq && !enq) full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!reset) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
            full_q    <= 1'b0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            full_q    <= full_d;
        end
    end

    // Equal pointers mean empty or full; the full bit disambiguates.
    always_comb begin
        if (enq_ptr_q >= deq_ptr_q) occupancy = cnt_w'(enq_ptr_q - deq_ptr_q);
        else                        occupancy = cnt_w'(p_num_entries) - cnt_w'(deq_ptr_q - enq_ptr_q);
        num_free = full_q ? '0 : cnt_w'(p_num_entries) - occupancy;
    end

    assign enq_ptr = enq_ptr_q;
    assign deq_ptr = deq_ptr_q;
    assign full    = full_q;
    assign empty   = !full_q && (enq_ptr_q == deq_ptr_q);

endmodule

// File: rtl/vc_partitioned_queue.sv
// Queue statically partitioned between security domains. Each domain owns
// p_msgs_per_domain slots of one shared register file; every handshake and
// status output for a domain is derived only from that domain's partition
// and same-domain inputs, so one domain cannot observe another's traffic.
//
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   enq_domain/enq_val/enq_rdy/enq_msg : producer side, tagged with a domain
//   deq_domain/deq_val/deq_rdy/deq_msg : consumer side, reads one domain
//   flush                          : per-domain partition clear
//   num_free                       : per-domain free count, domain 0 in the LSBs
module vc_partitioned_queue
    import vc_queue_pkg::*;
#(
    parameter logic [3:0] p_type            = VC_QUEUE_NORMAL,
    parameter int         p_msg_nbits       = 32,
    parameter int         p_num_domains     = 2,
    parameter int         p_msgs_per_domain = 4,
    localparam int        dom_w             = idx_width(p_num_domains),
    localparam int        ptr_w             = $clog2(p_msgs_per_domain),
    localparam int        cnt_w             = ptr_w + 1,
    localparam int        depth             = p_num_domains * p_msgs_per_domain,
    localparam int        addr_w            = idx_width(depth)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [dom_w-1:0]                 enq_domain,
    input  logic                             enq_val,
    output logic                             enq_rdy,
    input  logic [p_msg_nbits-1:0]           enq_msg,
    input  logic [dom_w-1:0]                 deq_domain,
    output logic                             deq_val,
    input  logic                             deq_rdy,
    output logic [p_msg_nbits-1:0]           deq_msg,
    input  logic [p_num_domains-1:0]         flush,
    output logic [p_num_domains*cnt_w-1:0]   num_free
);

    localparam logic is_pipe   = |(p_type & VC_QUEUE_PIPE);
    localparam logic is_bypass = |(p_type & VC_QUEUE_BYPASS);

    logic [p_num_domains-1:0] enq_sel, deq_sel;
    logic [p_num_domains-1:0] full, empty;
    logic [p_num_domains-1:0] dom_enq_rdy, dom_deq_val, dom_bypass;
    logic [p_num_domains-1:0] do_enq, do_deq;
    logic [ptr_w-1:0]         enq_ptr [p_num_domains];
    logic [ptr_w-1:0]         deq_ptr [p_num_domains];
    logic [cnt_w-1:0]         dom_num_free [p_num_domains];

    logic [ptr_w-1:0]         enq_ptr_sel, deq_ptr_sel;
    logic                     deq_bypass_sel;
    logic [addr_w-1:0]        wr_addr, rd_addr;
    logic [p_msg_nbits-1:0]   mem_q [depth];

    for (genvar d = 0; d < p_num_domains; d++) begin : g_dom
        logic enq_fire, deq_fire, bypass_fire;

        // An out-of-range domain index matches no partition, so it sees
        // enq_rdy=0 and deq_val=0.
        assign enq_sel[d] = (enq_domain == dom_w'(d));
        assign deq_sel[d] = (deq_domain == dom_w'(d));

        assign dom_enq_rdy[d] = !flush[d] && (!full[d] || (is_pipe && deq_rdy && deq_sel[d]));
        assign dom_bypass[d]  = is_bypass && empty[d] && enq_val && enq_sel[d] && !flush[d];
        assign dom_deq_val[d] = (!flush[d] && !empty[d]) || dom_bypass[d];

        assign enq_fire    = enq_val && enq_sel[d] && dom_enq_rdy[d];
        assign deq_fire    = deq_rdy && deq_sel[d] && dom_deq_val[d];
        // A bypassed message passes straight through: no write, no pointer move.
        assign bypass_fire = dom_bypass[d] && deq_sel[d] && deq_rdy;
        assign do_enq[d]   = enq_fire && !bypass_fire;
        assign do_deq[d]   = deq_fire && !bypass_fire;

        vc_partition_queue_ctrl #(
            .p_num_entries (p_msgs_per_domain)
        ) u_ctrl (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush[d]),
            .enq      (do_enq[d]),
            .deq      (do_deq[d]),
            .enq_ptr  (enq_ptr[d]),
            .deq_ptr  (deq_ptr[d]),
            .full     (full[d]),
            .empty    (empty[d]),
            .num_free (dom_num_free[d])
        );

        assign num_free[d*cnt_w +: cnt_w] = dom_num_free[d];
    end

    assign enq_rdy = |(dom_enq_rdy & enq_sel);
    assign deq_val = |(dom_deq_val & deq_sel);

    always_comb begin
        enq_ptr_sel    = '0;
        deq_ptr_sel    = '0;
        deq_bypass_sel = 1'b0;
        for (int d = 0; d < p_num_domains; d++) begin
            if (enq_sel[d]) enq_ptr_sel = enq_ptr[d];
            if (deq_sel[d]) begin
                deq_ptr_sel    = deq_ptr[d];
                deq_bypass_sel = dom_bypass[d];
            end
        end
    end

    // Slot address is domain*entries + pointer: identical to {domain, ptr}
    // when the partition size is a power of two, and packs densely otherwise.
    always_comb begin
        wr_addr = addr_w'(int'(enq_domain) * p_msgs_per_domain + int'(enq_ptr_sel));
        rd_addr = '0;
        if (|deq_sel) rd_addr = addr_w'(int'(deq_domain) * p_msgs_per_domain + int'(deq_ptr_sel));
    end

    // NOTE: the storage array has no reset; validity lives entirely in the
    // per-partition pointers, so resetting the data would only cost logic.
    always_ff @(posedge clk) begin
        if (|do_enq) mem_q[wr_addr] <= enq_msg;
    end

    assign deq_msg = deq_bypass_sel ? enq_msg : mem_q[rd_addr];

endmodule

// File: tb/tb_vc_partitioned_queue.sv
// Drives three queue configurations (NORMAL/4 entries, PIPE/3 entries,
// BYPASS/4 entries) from shared stimulus and compares each against a
// queue-of-messages reference model every cycle, plus literal checks of
// hand-computed scenarios.
module tb_vc_partitioned_queue;
    import vc_queue_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [0:0]  enq_domain = '0;
    logic [0:0]  deq_domain = '0;
    logic        enq_val = 1'b0;
    logic        deq_rdy = 1'b0;
    logic [31:0] enq_msg = '0;
    logic [1:0]  flush = '0;

    logic        enq_rdy_n, deq_val_n, enq_rdy_p, deq_val_p, enq_rdy_b, deq_val_b;
    logic [31:0] deq_msg_n, deq_msg_p, deq_msg_b;
    logic [5:0]  nf_n, nf_p, nf_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one message queue per (instance, domain), index i*2+d.
    logic [31:0] mq [NI*2][$];

    always #5 clk = ~clk;

    vc_partitioned_queue #(.p_type(VC_QUEUE_NORMAL), .p_msgs_per_domain(4)) dut_n (
        .clk(clk), .reset(reset), .enq_domain(enq_domain), .enq_val(enq_val), .enq_rdy(enq_rdy_n),
        .enq_msg(enq_msg), .deq_domain(deq_domain), .deq_val(deq_val_n), .deq_rdy(deq_rdy),
        .deq_msg(deq_msg_n), .flush(flush), .num_free(nf_n));

    vc_partitioned_queue #(.p_type(VC_QUEUE_PIPE), .p_msgs_per_domain(3)) dut_p (
        .clk(clk), .reset(reset), .enq_domain(enq_domain), .enq_val(enq_val), .enq_rdy(enq_rdy_p),
        .enq_msg(enq_msg), .deq_domain(deq_domain), .deq_val(deq_val_p), .deq_rdy(deq_rdy),
        .deq_msg(deq_msg_p), .flush(flush), .num_free(nf_p));

    vc_partitioned_queue #(.p_type(VC_QUEUE_BYPASS), .p_msgs_per_domain(4)) dut_b (
        .clk(clk), .reset(reset), .enq_domain(enq_domain), .enq_val(enq_val), .enq_rdy(enq_rdy_b),
        .enq_msg(enq_msg), .deq_domain(deq_domain), .deq_val(deq_val_b), .deq_rdy(deq_rdy),
        .deq_msg(deq_msg_b), .flush(flush), .num_free(nf_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_of(input int i);
        return (i == 1) ? 3 : 4;
    endfunction
    function automatic bit pipe_of(input int i);
        return i == 1;
    endfunction
    function automatic bit byp_of(input int i);
        return i == 2;
    endfunction
    function automatic int occ(input int i, input int d);
        return mq[i*2+d].size();
    endfunction

    function automatic bit exp_enq_rdy(input int i);
        int ed = int'(enq_domain);
        if (flush[ed]) return 1'b0;
        return (occ(i, ed) < n_of(i)) || (pipe_of(i) && deq_rdy && deq_domain == enq_domain);
    endfunction

    function automatic bit exp_deq_val(input int i);
        int dd = int'(deq_domain);
        if (flush[dd]) return 1'b0;
        return (occ(i, dd) > 0) || (byp_of(i) && enq_val && enq_domain == deq_domain);
    endfunction

    function automatic logic [31:0] exp_deq_msg(input int i);
        int dd = int'(deq_domain);
        return (occ(i, dd) > 0) ? mq[i*2+dd][0] : enq_msg;
    endfunction

    function automatic logic [5:0] exp_nf(input int i);
        logic [5:0] r;
        r[2:0] = 3'(n_of(i) - occ(i, 0));
        r[5:3] = 3'(n_of(i) - occ(i, 1));
        return r;
    endfunction

    task automatic model_step(input int i);
        int  dd  = int'(deq_domain);
        int  ed  = int'(enq_domain);
        bit  ev  = exp_deq_val(i);
        bit  er  = exp_enq_rdy(i);
        bit  byp = byp_of(i) && occ(i, dd) == 0 && enq_val && ed == dd && deq_rdy && !flush[dd];
        if (!byp) begin
            if (ev && deq_rdy) void'(mq[i*2+dd].pop_front());
            if (enq_val && er) mq[i*2+ed].push_back(enq_msg);
        end
        for (int d = 0; d < 2; d++) if (flush[d]) mq[i*2+d].delete();
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NI*2; k++) mq[k].delete();
        end else begin
            for (int i = 0; i < NI; i++) model_step(i);
        end
    end

    task automatic compare_inst(input int i, input logic rdy, input logic val,
                                input logic [31:0] msg, input logic [5:0] nf);
        string tag = $sformatf("u%0d", i);
        check({tag, ".enq_rdy"}, 32'(rdy), 32'(exp_enq_rdy(i)));
        check({tag, ".deq_val"}, 32'(val), 32'(exp_deq_val(i)));
        if (exp_deq_val(i)) check({tag, ".deq_msg"}, msg, exp_deq_msg(i));
        check({tag, ".num_free"}, 32'(nf), 32'(exp_nf(i)));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            compare_inst(0, enq_rdy_n, deq_val_n, deq_msg_n, nf_n);
            compare_inst(1, enq_rdy_p, deq_val_p, deq_msg_p, nf_p);
            compare_inst(2, enq_rdy_b, deq_val_b, deq_msg_b, nf_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        flush   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic rand_inputs(input int enq_pct, input int deq_pct, input bit use_flush);
        enq_val    = ($urandom_range(0, 99) < enq_pct);
        deq_rdy    = ($urandom_range(0, 99) < deq_pct);
        enq_domain = 1'($urandom_range(0, 1));
        deq_domain = 1'($urandom_range(0, 1));
        enq_msg    = $urandom;
        flush[0]   = use_flush && ($urandom_range(0, 39) == 0);
        flush[1]   = use_flush && ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        #3;
        check("rst.enq_rdy_n", 32'(enq_rdy_n), 32'd1);
        check("rst.deq_val_n", 32'(deq_val_n), 32'd0);
        check("rst.num_free_n", 32'(nf_n), 32'h24);
        check("rst.num_free_p", 32'(nf_p), 32'h1b);
        check("rst.deq_val_b", 32'(deq_val_b), 32'd0);
        tick();
        reset = 1'b1;

        // Fill domain 1 of the 4-entry queue, then offer a fifth.
        enq_domain = 1'b1;
        deq_domain = 1'b1;
        for (int k = 0; k < 4; k++) begin
            enq_val = 1'b1;
            enq_msg = 32'h100 + 32'(k);
            tick();
        end
        enq_msg = 32'h1ff;
        #1;
        check("full.enq_rdy_d1", 32'(enq_rdy_n), 32'd0);
        check("full.num_free_d1", 32'(nf_n[5:3]), 32'd0);
        check("full.num_free_d0", 32'(nf_n[2:0]), 32'd4);
        enq_val    = 1'b0;
        enq_domain = 1'b0;
        #1;
        check("full.enq_rdy_d0", 32'(enq_rdy_n), 32'd1);

        // One message into domain 0, drain two from domain 1.
        enq_val = 1'b1;
        enq_msg = 32'h200;
        tick();
        enq_val = 1'b0;
        deq_rdy = 1'b1;
        #1;
        check("drain.msg0", deq_msg_n, 32'h100);
        tick();
        check("drain.msg1", deq_msg_n, 32'h101);
        tick();

        // Flush domain 1 while it is offered a message.
        deq_rdy    = 1'b0;
        flush      = 2'b10;
        enq_val    = 1'b1;
        enq_domain = 1'b1;
        enq_msg    = 32'hbad;
        #1;
        check("flush.enq_rdy", 32'(enq_rdy_n), 32'd0);
        check("flush.deq_val", 32'(deq_val_n), 32'd0);
        tick();
        idle();
        #1;
        check("flush.num_free_d1", 32'(nf_n[5:3]), 32'd4);
        check("flush.num_free_d0", 32'(nf_n[2:0]), 32'd3);
        deq_domain = 1'b0;
        #1;
        check("flush.d0_val", 32'(deq_val_n), 32'd1);
        check("flush.d0_msg", deq_msg_n, 32'h200);

        // Fill domain 0, then cross-domain enqueue and dequeue together.
        enq_domain = 1'b0;
        for (int k = 1; k < 4; k++) begin
            enq_val = 1'b1;
            enq_msg = 32'h200 + 32'(k);
            tick();
        end
        enq_val = 1'b0;
        #1;
        check("xdom.d0_full", 32'(nf_n[2:0]), 32'd0);
        enq_val    = 1'b1;
        enq_domain = 1'b1;
        enq_msg    = 32'ha5;
        deq_domain = 1'b0;
        deq_rdy    = 1'b1;
        #1;
        check("xdom.enq_rdy", 32'(enq_rdy_n), 32'd1);
        check("xdom.deq_val", 32'(deq_val_n), 32'd1);
        check("xdom.deq_msg", deq_msg_n, 32'h200);
        tick();
        idle();
        #1;
        check("xdom.num_free", 32'(nf_n), 32'h19);
        deq_domain = 1'b1;
        #1;
        check("xdom.d1_msg", deq_msg_n, 32'ha5);

        // Three-entry partition: seven enqueue/dequeue pairs across the wrap.
        do_reset();
        enq_domain = 1'b0;
        deq_domain = 1'b0;
        for (int k = 0; k < 7; k++) begin
            enq_val = 1'b1;
            deq_rdy = 1'b0;
            enq_msg = 32'h300 + 32'(k);
            tick();
            enq_val = 1'b0;
            deq_rdy = 1'b1;
            #1;
            check($sformatf("wrap.msg%0d", k), deq_msg_p, 32'h300 + 32'(k));
            tick();
        end
        idle();
        #1;
        check("wrap.num_free", 32'(nf_p[2:0]), 32'd3);

        // Bypass through an empty partition.
        do_reset();
        enq_val    = 1'b1;
        enq_domain = 1'b0;
        enq_msg    = 32'h1234;
        deq_domain = 1'b0;
        deq_rdy    = 1'b1;
        #1;
        check("byp.deq_val", 32'(deq_val_b), 32'd1);
        check("byp.deq_msg", deq_msg_b, 32'h1234);
        tick();
        idle();
        #1;
        check("byp.num_free", 32'(nf_b), 32'h24);
        check("byp.deq_val_after", 32'(deq_val_b), 32'd0);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rand_inputs(70, 60, 1'b1);
            tick();
        end

        // Asynchronous reset mid-burst, away from the clock edge.
        for (int c = 0; c < 6; c++) begin
            rand_inputs(90, 10, 1'b0);
            tick();
        end
        idle();
        enq_domain = 1'b0;
        deq_domain = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst.enq_rdy_n", 32'(enq_rdy_n), 32'd1);
        check("arst.deq_val_n", 32'(deq_val_n), 32'd0);
        check("arst.num_free_n", 32'(nf_n), 32'h24);
        check("arst.enq_rdy_p", 32'(enq_rdy_p), 32'd1);
        check("arst.deq_val_p", 32'(deq_val_p), 32'd0);
        check("arst.num_free_p", 32'(nf_p), 32'h1b);
        check("arst.enq_rdy_b", 32'(enq_rdy_b), 32'd1);
        check("arst.deq_val_b", 32'(deq_val_b), 32'd0);
        check("arst.num_free_b", 32'(nf_b), 32'h24);
        tick();
        tick();
        reset   = 1'b1;
        deq_rdy = 1'b1;
        for (int d = 0; d < 2; d++) begin
            deq_domain = 1'(d);
            #1;
            check($sformatf("arst.stale_n_d%0d", d), 32'(deq_val_n), 32'd0);
            check($sformatf("arst.stale_p_d%0d", d), 32'(deq_val_p), 32'd0);
            check($sformatf("arst.stale_b_d%0d", d), 32'(deq_val_b), 32'd0);
        end
        tick();
        for (int c = 0; c < 100; c++) begin
            rand_inputs(60, 60, 1'b1);
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
